// File: rtl/servo_pkg.sv
// Shared types and arithmetic helpers for the servo command scheduler.
package servo_pkg;

  localparam int COORD_W_DEFAULT = 12;

  typedef logic [COORD_W_DEFAULT-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    ISSUE  = 2'd2,
    SETTLE = 2'd3
  } state_e;

  function automatic int clamp_step(input int d, input int max_step);
    if (d > max_step) begin
      return max_step;
    end else if (d < -max_step) begin
      return -max_step;
    end else begin
      return d;
    end
  endfunction

  function automatic int sat_range(input int v, input int lo, input int hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/servo_cmd_scheduler_if.sv
// Valid/ready command bus from the scheduler to the servo pipeline.
interface servo_cmd_scheduler_if #(
  parameter int COORD_W = servo_pkg::COORD_W_DEFAULT
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;

  modport master (output cmd_valid, output cmd_x, output cmd_y, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_x, input cmd_y, output cmd_ready);
endinterface

// File: rtl/servo_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module servo_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Counter wraps at TICK_DIV-1; the tick flop fires on the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == CW'(TICK_DIV - 1)) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;
endmodule

// File: rtl/servo_cmd_scheduler.sv
// Slews the servo command toward a goal in bounded steps, one per tick, then settles.
// Optional goal soft limits and the limit_hit output are enabled by SERVO_SOFT_LIMIT_EN.
module servo_cmd_scheduler #(
  parameter int COORD_W      = servo_pkg::COORD_W_DEFAULT,
  parameter int MAX_STEP     = 16,
  parameter int TICK_DIV     = 50000,
  parameter int SETTLE_TICKS = 4,
  parameter int HOME_X       = 2048,
  parameter int HOME_Y       = 2048
`ifdef SERVO_SOFT_LIMIT_EN
  ,
  parameter int X_MIN        = 256,
  parameter int X_MAX        = 3840,
  parameter int Y_MIN        = 256,
  parameter int Y_MAX        = 3840
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tgt_valid,
  input  logic [COORD_W-1:0]   tgt_x,
  input  logic [COORD_W-1:0]   tgt_y,
  input  logic                 home_req,
  servo_cmd_scheduler_if.master cmd,
  output logic                 on_target,
  output logic                 busy
`ifdef SERVO_SOFT_LIMIT_EN
  ,
  output logic                 limit_hit
`endif
);
  import servo_pkg::*;

  localparam int SW = $clog2(SETTLE_TICKS + 1);
`ifdef SERVO_SOFT_LIMIT_EN
  localparam int HOME_X_EFF = sat_range(HOME_X, X_MIN, X_MAX);
  localparam int HOME_Y_EFF = sat_range(HOME_Y, Y_MIN, Y_MAX);
`else
  localparam int HOME_X_EFF = HOME_X;
  localparam int HOME_Y_EFF = HOME_Y;
`endif
  localparam logic [COORD_W-1:0] HOME_XC = COORD_W'(HOME_X_EFF);
  localparam logic [COORD_W-1:0] HOME_YC = COORD_W'(HOME_Y_EFF);

  state_e               state_q;
  logic [COORD_W-1:0]   cur_x_q, cur_y_q, goal_x_q, goal_y_q, cmd_x_q, cmd_y_q;
  logic                 cmd_valid_q, on_target_q, limit_hit_q;
  logic [SW-1:0]        settle_q;
  logic                 tick_s, goal_wr_s, goal_chg_s, clip_s;
  logic [COORD_W-1:0]   raw_x_s, raw_y_s, goal_x_d, goal_y_d, next_x_d, next_y_d;
  logic signed [COORD_W:0] dx_s, dy_s;

  servo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick_s)
  );

  // Candidate goal: home wins over an explicit target, optionally saturated.
  always_comb begin
    goal_wr_s = home_req | tgt_valid;
    raw_x_s   = home_req ? COORD_W'(HOME_X) : tgt_x;
    raw_y_s   = home_req ? COORD_W'(HOME_Y) : tgt_y;
`ifdef SERVO_SOFT_LIMIT_EN
    goal_x_d  = COORD_W'(sat_range(int'(raw_x_s), X_MIN, X_MAX));
    goal_y_d  = COORD_W'(sat_range(int'(raw_y_s), Y_MIN, Y_MAX));
`else
    goal_x_d  = raw_x_s;
    goal_y_d  = raw_y_s;
`endif
    clip_s     = goal_wr_s && ((goal_x_d != raw_x_s) || (goal_y_d != raw_y_s));
    goal_chg_s = goal_wr_s && ((goal_x_d != goal_x_q) || (goal_y_d != goal_y_q));
  end

  // Next step: the signed distance is one bit wider so it never wraps.
  always_comb begin
    dx_s     = $signed({1'b0, goal_x_q}) - $signed({1'b0, cur_x_q});
    dy_s     = $signed({1'b0, goal_y_q}) - $signed({1'b0, cur_y_q});
    next_x_d = COORD_W'(int'(cur_x_q) + clamp_step(int'(dx_s), MAX_STEP));
    next_y_d = COORD_W'(int'(cur_y_q) + clamp_step(int'(dy_s), MAX_STEP));
  end

  // Scheduler FSM with goal register and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ISSUE;
      cur_x_q     <= HOME_XC;
      cur_y_q     <= HOME_YC;
      goal_x_q    <= HOME_XC;
      goal_y_q    <= HOME_YC;
      cmd_x_q     <= HOME_XC;
      cmd_y_q     <= HOME_YC;
      cmd_valid_q <= 1'b1;
      on_target_q <= 1'b0;
      settle_q    <= '0;
      limit_hit_q <= 1'b0;
    end else begin
      if (goal_wr_s) begin
        goal_x_q <= goal_x_d;
        goal_y_q <= goal_y_d;
      end
      limit_hit_q <= clip_s;
      case (state_q)
        IDLE: begin
          if ((cur_x_q != goal_x_q) || (cur_y_q != goal_y_q)) begin
            state_q     <= STEP;
            on_target_q <= 1'b0;
          end else begin
            on_target_q <= 1'b1;
          end
        end
        STEP: begin
          if (tick_s) begin
            if ((cur_x_q == goal_x_q) && (cur_y_q == goal_y_q)) begin
              state_q  <= SETTLE;
              settle_q <= '0;
            end else begin
              cmd_x_q     <= next_x_d;
              cmd_y_q     <= next_y_d;
              cmd_valid_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (cmd_valid_q && cmd.cmd_ready) begin
            cur_x_q     <= cmd_x_q;
            cur_y_q     <= cmd_y_q;
            cmd_valid_q <= 1'b0;
            if ((cmd_x_q == goal_x_q) && (cmd_y_q == goal_y_q)) begin
              state_q  <= SETTLE;
              settle_q <= '0;
            end else begin
              state_q <= STEP;
            end
          end
        end
        SETTLE: begin
          // A goal that moved away from cur restarts the approach.
          if ((cur_x_q != goal_x_q) || (cur_y_q != goal_y_q)) begin
            state_q  <= STEP;
            settle_q <= '0;
          end else if (tick_s) begin
            if (settle_q == SW'(SETTLE_TICKS - 1)) begin
              state_q     <= IDLE;
              on_target_q <= 1'b1;
            end else begin
              settle_q <= settle_q + SW'(1);
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_valid_q <= 1'b0;
          on_target_q <= 1'b0;
        end
      endcase
      if (goal_chg_s) begin
        on_target_q <= 1'b0;
      end
    end
  end

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_x     = cmd_x_q;
  assign cmd.cmd_y     = cmd_y_q;
  assign on_target     = on_target_q;
  assign busy          = (state_q != IDLE);
`ifdef SERVO_SOFT_LIMIT_EN
  assign limit_hit     = limit_hit_q;
`endif
endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Directed bench for servo_cmd_scheduler with TICK_DIV=4, SETTLE_TICKS=2, MAX_STEP=16.
module tb_servo_cmd_scheduler;
  import servo_pkg::*;

  localparam int TD    = 4;
  localparam int ST    = 2;
  localparam int MS    = 16;
  localparam int BOUND = 64;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   tgt_valid = 1'b0;
  logic   home_req = 1'b0;
  coord_t tgt_x = '0;
  coord_t tgt_y = '0;
  logic   on_target, busy;
`ifdef SERVO_SOFT_LIMIT_EN
  logic   limit_hit;
`endif

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int ot_cnt = 0;

  servo_cmd_scheduler_if #(.COORD_W(COORD_W_DEFAULT)) bus ();

  servo_cmd_scheduler #(
    .COORD_W(COORD_W_DEFAULT), .MAX_STEP(MS), .TICK_DIV(TD), .SETTLE_TICKS(ST),
    .HOME_X(2048), .HOME_Y(2048)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_x     (tgt_x),
    .tgt_y     (tgt_y),
    .home_req  (home_req),
    .cmd       (bus),
    .on_target (on_target),
    .busy      (busy)
`ifdef SERVO_SOFT_LIMIT_EN
    ,
    .limit_hit (limit_hit)
`endif
  );

  always #5 clk = ~clk;

  // on_target must never coexist with busy
  always @(negedge clk) begin
    if (rst === 1'b0 && on_target === 1'b1 && busy === 1'b1) viol <= viol + 1;
    if (on_target === 1'b1) ot_cnt <= ot_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_goal(input int x, input int y, input logic v, input logic h);
    @(posedge clk); #1;
    tgt_x = coord_t'(x); tgt_y = coord_t'(y); tgt_valid = v; home_req = h;
    @(posedge clk); #1;
    tgt_valid = 1'b0; home_req = 1'b0;
  endtask

  // Wait for cmd_valid; if ready is high, also step past the accepting edge.
  task automatic wait_cmd(input string tag, output logic [31:0] x, output logic [31:0] y,
                          output int cyc);
    logic got;
    got = 1'b0; cyc = 0; x = '0; y = '0;
    while (!got && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (bus.cmd_valid === 1'b1) begin
        got = 1'b1; x = 32'(bus.cmd_x); y = 32'(bus.cmd_y);
      end
    end
    chk({tag, "_cmd_seen"}, 32'(got), 32'd1);
    if (got && bus.cmd_ready === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ontgt(input string tag, output int cyc, output int ncmd,
                            output logic busy_at);
    logic got;
    got = 1'b0; cyc = 0; ncmd = 0; busy_at = 1'bx;
    while (!got && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      if (bus.cmd_valid === 1'b1) ncmd++;
      if (on_target === 1'b1) begin
        got = 1'b1; busy_at = busy;
      end
    end
    chk({tag, "_ontgt_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic [31:0] x, y;
    int          cyc, ncmd, bad, nvalid, nlow, snap;
    logic        busy_at;
    int          ex[4] = '{2064, 2080, 2096, 2100};
    int          ey[4] = '{2032, 2016, 2000, 2000};

    bus.cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.cmd_valid), 32'd1);
    chk("rst_cmd_x", 32'(bus.cmd_x), 32'd2048);
    chk("rst_cmd_y", 32'(bus.cmd_y), 32'd2048);
    chk("rst_ontgt", 32'(on_target), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Homing command, then settle for ST ticks
    wait_cmd("home", x, y, cyc);
    chk("home_cmd_x", x, 32'd2048);
    chk("home_cmd_y", y, 32'd2048);
    wait_ontgt("home", cyc, ncmd, busy_at);
    chk("home_settle_window", 32'(cyc > TD && cyc <= 2 * TD + 1), 32'd1);
    chk("home_busy_fall", 32'(busy_at), 32'd0);
    chk("home_no_extra_cmd", 32'(ncmd), 32'd0);

    // Target and home together: home wins, already there
    load_goal(3000, 3000, 1'b1, 1'b1);
    nvalid = 0; nlow = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (bus.cmd_valid !== 1'b0) nvalid++;
      if (on_target !== 1'b1) nlow++;
    end
    chk("homewin_no_cmd", 32'(nvalid), 32'd0);
    chk("homewin_ontgt_held", 32'(nlow), 32'd0);

    // Multi-step slew to (2100, 2000)
    load_goal(2100, 2000, 1'b1, 1'b0);
    @(negedge clk);
    chk("slew_ontgt_cleared", 32'(on_target), 32'd0);
    for (int k = 0; k < 4; k++) begin
      wait_cmd("slew", x, y, cyc);
      chk($sformatf("slew_x%0d", k), x, 32'(ex[k]));
      chk($sformatf("slew_y%0d", k), y, 32'(ey[k]));
      if (k > 0) chk($sformatf("slew_spacing%0d", k), 32'(cyc), 32'(TD));
    end
    wait_ontgt("slew", cyc, ncmd, busy_at);
    chk("slew_settle_window", 32'(cyc > TD && cyc <= 2 * TD + 1), 32'd1);
    chk("slew_busy_fall", 32'(busy_at), 32'd0);
    chk("slew_no_extra_cmd", 32'(ncmd), 32'd0);

    // New goal after the first settle tick restarts the approach
    load_goal(2110, 2000, 1'b1, 1'b0);
    wait_cmd("intr_a", x, y, cyc);
    chk("intr_a_x", x, 32'd2110);
    chk("intr_a_y", y, 32'd2000);
    snap = ot_cnt;
    repeat (4) @(posedge clk);
    #1;
    tgt_x = 12'd2120; tgt_y = 12'd2000; tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    wait_cmd("intr_b", x, y, cyc);
    chk("intr_b_x", x, 32'd2120);
    chk("intr_b_y", y, 32'd2000);
    chk("intr_ontgt_low", 32'(ot_cnt - snap), 32'd0);
    wait_ontgt("intr", cyc, ncmd, busy_at);
    chk("intr_settle_restart", 32'(cyc > TD && cyc <= 2 * TD + 1), 32'd1);

    // Backpressure: command held while the goal changes underneath
    bus.cmd_ready = 1'b0;
    load_goal(2200, 2000, 1'b1, 1'b0);
    wait_cmd("hold", x, y, cyc);
    chk("hold_first_x", x, 32'd2136);
    chk("hold_first_y", y, 32'd2000);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tgt_valid = (i == 10); tgt_x = '0; tgt_y = '0;
      @(negedge clk);
      if (bus.cmd_valid !== 1'b1 || bus.cmd_x !== 12'd2136 || bus.cmd_y !== 12'd2000) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    @(posedge clk); #1;
    bus.cmd_ready = 1'b1;
    @(posedge clk); #1;
    wait_cmd("redir", x, y, cyc);
    chk("redir_x", x, 32'd2120);
    chk("redir_y", y, 32'd1984);
    load_goal(2120, 1984, 1'b1, 1'b0);
    wait_ontgt("park", cyc, ncmd, busy_at);
    chk("park_no_cmd", 32'(ncmd), 32'd0);

`ifdef SERVO_SOFT_LIMIT_EN
    load_goal(4000, 100, 1'b1, 1'b0);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (limit_hit === 1'b1) nvalid++;
    end
    chk("limit_hit_pulses", 32'(nvalid), 32'd1);
    chk("limit_goal_x", 32'(dut.goal_x_q), 32'd3840);
    chk("limit_goal_y", 32'(dut.goal_y_q), 32'd256);
`endif

    // Reset while a command is stalled: homing command replaces it
    bus.cmd_ready = 1'b0;
    load_goal(2300, 2000, 1'b1, 1'b0);
    wait_cmd("prerst", x, y, cyc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rsths_valid", 32'(bus.cmd_valid), 32'd1);
    chk("rsths_x", 32'(bus.cmd_x), 32'd2048);
    chk("rsths_y", 32'(bus.cmd_y), 32'd2048);
    chk("rsths_ontgt", 32'(on_target), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cmd_ready = 1'b1;
    wait_cmd("rehome", x, y, cyc);
    chk("rehome_x", x, 32'd2048);
    chk("rehome_y", y, 32'd2048);
    wait_ontgt("rehome", cyc, ncmd, busy_at);
    chk("rehome_busy_fall", 32'(busy_at), 32'd0);

    chk("ontgt_while_busy", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/servo_cmd_scheduler.md
Name: servo_cmd_scheduler

Overview:
- Sits between the tracking state machine and the servo pipeline. Accepts target coordinates and slews the servos toward them in bounded steps, one step per update tick.
- Each step is issued to the servo pipeline over a valid/ready handshake.
- After the final step, the block waits a settle interval before reporting on_target, which gates the fire decision.

Parameters:
- COORD_W, 12, coordinate width in bits, unsigned.
- MAX_STEP, 16, maximum per-axis change per issued command.
- TICK_DIV, 50000, clk cycles per update tick (>=2).
- SETTLE_TICKS, 4, ticks to wait after the final step before on_target (>=1).
- HOME_X, 2048, home/reset X coordinate.
- HOME_Y, 2048, home/reset Y coordinate.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tgt_valid  in  1  load tgt_x/tgt_y as new goal this cycle
- tgt_x  in  COORD_W  requested X
- tgt_y  in  COORD_W  requested Y
- home_req  in  1  force goal to HOME_X/HOME_Y
- cmd_valid  out  1  command to servo pipeline valid
- cmd_ready  in  1  servo pipeline accepts command
- cmd_x  out  COORD_W  commanded X
- cmd_y  out  COORD_W  commanded Y
- on_target  out  1  servos settled at goal
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - cur = goal = HOME.
  - cmd_x/cmd_y = HOME, cmd_valid = 1 (one homing command).
  - on_target = 0, tick counter = 0, settle counter = 0.
  - State = ISSUE.
- Tick: free-running counter 0..TICK_DIV-1; tick pulses one cycle at wrap. It never stops or resets except on rst.
- Goal register: home_req loads HOME; else tgt_valid loads tgt_x/tgt_y. home_req wins when both are asserted. The goal is loadable in every state.
- A goal write that differs from the current goal clears on_target in the same cycle (registered, visible next cycle).
- FSM states: IDLE, STEP, ISSUE, SETTLE.
- IDLE: if cur != goal -> STEP. Otherwise hold, with on_target = 1.
- STEP: wait for tick. On tick:
  - Per axis, d = goal - cur as a signed COORD_W+1 value.
  - next = cur + clamp(d, -MAX_STEP, +MAX_STEP).
  - Load cmd_x/cmd_y = next, assert cmd_valid -> ISSUE.
  - If cur == goal on tick, go to SETTLE instead.
- ISSUE:
  - cmd_valid, cmd_x and cmd_y are held stable until cmd_ready, even if the goal changes.
  - On cmd_valid && cmd_ready: cur <= cmd, cmd_valid <= 0.
  - If cmd == goal -> SETTLE (settle counter cleared), else -> STEP.
- SETTLE:
  - Count ticks. At SETTLE_TICKS -> IDLE with on_target = 1.
  - If the goal changes mid-settle -> STEP; settle count is discarded.
- Latency: a goal within MAX_STEP of cur reaches on_target after 1 tick + handshake + SETTLE_TICKS ticks.
- Arithmetic: no overflow. The clamped step never overshoots the goal, and next always lies between cur and goal.
- on_target is 0 whenever busy is 1.
- Reset mid-handshake: the pending command is abandoned and the homing command is reissued.

Optional Feature:
- Macro: SERVO_SOFT_LIMIT_EN.
- When defined:
  - Adds parameters X_MIN, X_MAX, Y_MIN, Y_MAX (defaults 256, 3840, 256, 3840).
  - Every loaded goal, including HOME, is saturated into [MIN, MAX] per axis before storage.
  - Adds output limit_hit (1 bit), pulsing one cycle whenever a loaded goal was clipped.
- When not defined: goals are stored unmodified and limit_hit does not exist.

Decomposition:
- Package servo_pkg holds:
  - COORD_W default;
  - FSM state enum type (IDLE, STEP, ISSUE, SETTLE);
  - a coord_t typedef;
  - a clamp_step function.
- One sub-module, servo_tick_gen: parameterised by TICK_DIV, outputs the tick pulse. It is reused by other timing blocks.

Test Plan:
- Reset, cmd_ready held 1, TICK_DIV=4, SETTLE_TICKS=2:
  - one command (2048, 2048) is issued;
  - on_target rises after 2 ticks;
  - busy then falls.
- Goal (2100, 2000) from home, MAX_STEP=16 -> commands X 2064, 2080, 2096, 2100 and Y 2032, 2016, 2000, 2000; one command per tick; on_target after the final settle.
- cmd_ready held 0 for 20 cycles in ISSUE, with a new tgt_valid (0, 0) mid-hold -> cmd_x/cmd_y stay unchanged until cmd_ready; the next step then heads toward (0, 0).
- tgt_valid (3000, 3000) and home_req in the same cycle -> goal = (2048, 2048); no command issued; on_target stays 1.
- New goal during SETTLE (count 1 of 4) -> on_target stays 0; FSM returns to STEP; the settle count restarts after the final step.
- With SERVO_SOFT_LIMIT_EN: goal (4000, 100) -> goal stored as (3840, 256); limit_hit pulses exactly one cycle.
